// File: rtl/bist_ch_pkg.sv
// Shared definitions for the per-channel BIST register responder:
// register offsets, run-state encoding and the unmapped-read pattern.
package bist_ch_pkg;

   localparam logic [3:0] OFF_CTRL      = 4'h0;
   localparam logic [3:0] OFF_SEED      = 4'h1;
   localparam logic [3:0] OFF_STATUS    = 4'h2;
   localparam logic [3:0] OFF_FRAME_CNT = 4'h3;
   localparam logic [3:0] OFF_ERR_CNT   = 4'h4;
   localparam logic [3:0] OFF_SCRATCH   = 4'h5;

   localparam logic [31:0] UNMAP_PAT = 32'h5555_AAAA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } bist_state_e;

endpackage

// File: rtl/bist_ch_fsm.sv
// BIST run sequencer: state register, frame/error counters, start pulse,
// busy flag and the seed presented to the traffic engine.
//
// state   | meaning
// IDLE    | waiting for an accepted START
// ARM     | counters cleared, oBIST_START pulsed, seed held
// RUN     | counting frames and errors until target or ABORT
// DONE    | one cycle, raises the DONE sticky bit
module bist_ch_fsm
   import bist_ch_pkg::*;
#(
   parameter logic [31:0] DEF_SEED = 32'h1,
   parameter int          ERR_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_req,
   input  logic             abort_req,
   input  logic             continuous,
   input  logic [15:0]      frame_target,
   input  logic [31:0]      seed_reg,
   input  logic             frame_done,
   input  logic             err_in,
   output logic [1:0]       state,
   output logic [47:0]      frame_cnt,
   output logic [ERR_W-1:0] err_cnt,
   output logic             err_hit,
   output logic             bist_start,
   output logic             bist_busy,
   output logic [31:0]      bist_seed
);

   bist_state_e      state_q, state_d;
   logic [47:0]      frame_cnt_q, frame_cnt_d, frame_inc;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [31:0]      bist_seed_q, bist_seed_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         bist_seed_q <= DEF_SEED;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         bist_seed_q <= bist_seed_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      bist_seed_d = bist_seed_q;
      err_hit     = 1'b0;
      frame_inc   = frame_cnt_q + 48'd1;
      case (state_q)
         ST_IDLE: begin
            // Seed is captured on entry so it is already stable while START pulses.
            if (start_req) begin
               state_d     = ST_ARM;
               bist_seed_d = seed_reg;
            end
         end
         ST_ARM: begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            if (frame_done) begin
               frame_cnt_d = frame_inc;
               if (!continuous && (frame_inc == {32'd0, frame_target}))
                  state_d = ST_DONE;
            end
            if (err_in) begin
               err_hit = 1'b1;
               if (err_cnt_q != '1)
                  err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (abort_req)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state      = state_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign bist_start = (state_q == ST_ARM);
   assign bist_busy  = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign bist_seed  = bist_seed_q;

endmodule

// File: rtl/bist_ch_csr.sv
// Per-channel BIST register responder: decode, sticky status, read mux.
// Define BIST_CH_CSR_SNAPSHOT_EN to make ERR_CNT reads return a shadow captured on FRAME_CNT reads.
module bist_ch_csr
   import bist_ch_pkg::*;
#(
   parameter logic [31:0] DEF_SEED = 32'h1,
   parameter int          ERR_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] iMM_ADDR,
   input  logic [63:0] iMM_WR_DATA,
   input  logic        iMM_WR_EN,
   input  logic        iMM_RD_EN,
   output logic [63:0] oMM_RD_DATA,
   output logic        oMM_RD_DATA_V,
   output logic        oBIST_START,
   output logic [31:0] oBIST_SEED,
   output logic        oBIST_BUSY,
   input  logic        iBIST_FRAME_DONE,
   input  logic        iBIST_ERR
);

   logic [3:0]       off;
   logic             wr_ctrl, start_req, abort_req, err_hit;
   logic [1:0]       state;
   logic [47:0]      frame_cnt;
   logic [ERR_W-1:0] err_cnt, err_view;

   logic             cont_q, cont_d, done_q, done_d, err_q, err_d, rd_v_q, rd_v_d;
   logic [15:0]      target_q, target_d;
   logic [31:0]      seed_q, seed_d;
   logic [63:0]      scratch_q, scratch_d, rd_data_q, rd_data_d, rd_mux;

   assign off       = iMM_ADDR[3:0];
   assign wr_ctrl   = iMM_WR_EN && (off == OFF_CTRL);
   assign start_req = wr_ctrl && iMM_WR_DATA[0] && (iMM_WR_DATA[47:32] != 16'd0);
   assign abort_req = wr_ctrl && iMM_WR_DATA[1];

   bist_ch_fsm #(.DEF_SEED(DEF_SEED), .ERR_W(ERR_W)) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .start_req    (start_req),
      .abort_req    (abort_req),
      .continuous   (cont_q),
      .frame_target (target_q),
      .seed_reg     (seed_q),
      .frame_done   (iBIST_FRAME_DONE),
      .err_in       (iBIST_ERR),
      .state        (state),
      .frame_cnt    (frame_cnt),
      .err_cnt      (err_cnt),
      .err_hit      (err_hit),
      .bist_start   (oBIST_START),
      .bist_busy    (oBIST_BUSY),
      .bist_seed    (oBIST_SEED)
   );

`ifdef BIST_CH_CSR_SNAPSHOT_EN
   logic [ERR_W-1:0] shadow_q, shadow_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) shadow_q <= '0;
      else     shadow_q <= shadow_d;
   end

   always_comb begin
      shadow_d = shadow_q;
      if (state == ST_ARM)
         shadow_d = '0;
      else if (iMM_RD_EN && (off == OFF_FRAME_CNT))
         shadow_d = err_cnt;
   end

   assign err_view = shadow_q;
`else
   assign err_view = err_cnt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cont_q    <= 1'b0;
         target_q  <= '0;
         seed_q    <= DEF_SEED;
         scratch_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_v_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         cont_q    <= cont_d;
         target_q  <= target_d;
         seed_q    <= seed_d;
         scratch_q <= scratch_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rd_v_q    <= rd_v_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      cont_d    = cont_q;
      target_d  = target_q;
      seed_d    = seed_q;
      scratch_d = scratch_q;
      done_d    = done_q;
      err_d     = err_q;
      if (iMM_WR_EN) begin
         case (off)
            OFF_CTRL: begin
               cont_d   = iMM_WR_DATA[2];
               target_d = iMM_WR_DATA[47:32];
            end
            OFF_SEED:    seed_d    = iMM_WR_DATA[31:0];
            OFF_STATUS: begin
               done_d = done_q & ~iMM_WR_DATA[2];
               err_d  = err_q  & ~iMM_WR_DATA[3];
            end
            OFF_SCRATCH: scratch_d = iMM_WR_DATA;
            default: ;
         endcase
      end
      // Hardware set is applied after the clear so a coincident event is never lost.
      if (state == ST_DONE) done_d = 1'b1;
      if (err_hit)          err_d  = 1'b1;
   end

   always_comb begin
      case (off)
         OFF_CTRL:      rd_mux = {16'd0, target_q, 29'd0, cont_q, 2'b00};
         OFF_SEED:      rd_mux = {32'd0, seed_q};
         OFF_STATUS:    rd_mux = {60'd0, err_q, done_q, state};
         OFF_FRAME_CNT: rd_mux = {16'd0, frame_cnt};
         OFF_ERR_CNT:   rd_mux = 64'(err_view);
         OFF_SCRATCH:   rd_mux = scratch_q;
         default:       rd_mux = {UNMAP_PAT, 15'd0, iMM_ADDR};
      endcase
      rd_v_d    = iMM_RD_EN;
      rd_data_d = iMM_RD_EN ? rd_mux : rd_data_q;
   end

   assign oMM_RD_DATA   = rd_data_q;
   assign oMM_RD_DATA_V = rd_v_q;

endmodule

// File: tb/tb_bist_ch_csr.sv
// Directed bench for bist_ch_csr: a vector table for the register map and run
// sequences, plus hand sequences for saturation, mid-run reset and the ERR_CNT shadow.
module tb_bist_ch_csr;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] addr;
   logic [63:0] wdata;
   logic        wr_en, rd_en, fdone, ferr;
   logic [63:0] rd_data, sat_rd_data;
   logic        rd_v, bstart, bbusy, sat_rd_v, sat_start, sat_busy;
   logic [31:0] bseed, sat_seed;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bist_ch_csr dut (
      .clk(clk), .rst(rst), .iMM_ADDR(addr), .iMM_WR_DATA(wdata),
      .iMM_WR_EN(wr_en), .iMM_RD_EN(rd_en), .oMM_RD_DATA(rd_data),
      .oMM_RD_DATA_V(rd_v), .oBIST_START(bstart), .oBIST_SEED(bseed),
      .oBIST_BUSY(bbusy), .iBIST_FRAME_DONE(fdone), .iBIST_ERR(ferr)
   );

   // Narrow error counter so saturation is reachable in a few cycles.
   bist_ch_csr #(.ERR_W(4)) dut_sat (
      .clk(clk), .rst(rst), .iMM_ADDR(addr), .iMM_WR_DATA(wdata),
      .iMM_WR_EN(wr_en), .iMM_RD_EN(rd_en), .oMM_RD_DATA(sat_rd_data),
      .oMM_RD_DATA_V(sat_rd_v), .oBIST_START(sat_start), .oBIST_SEED(sat_seed),
      .oBIST_BUSY(sat_busy), .iBIST_FRAME_DONE(fdone), .iBIST_ERR(ferr)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [16:0] a;
      logic [63:0] wd;
      logic        fd;
      logic        er;
      logic        ev;
      logic [63:0] erd;
      logic        es;
      logic        eb;
      logic [31:0] esd;
   } vec_t;

   vec_t vt[$];

   task automatic addv(input logic wr, input logic rd, input logic [16:0] a, input logic [63:0] wd,
                       input logic fd, input logic er, input logic ev, input logic [63:0] erd,
                       input logic es, input logic eb, input logic [31:0] esd);
      vt.push_back('{wr, rd, a, wd, fd, er, ev, erd, es, eb, esd});
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [16:0] a, input logic [63:0] wd,
                        input logic fd, input logic er);
      wr_en = wr; rd_en = rd; addr = a; wdata = wd; fdone = fd; ferr = er;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; fdone = 1'b0; ferr = 1'b0;
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic rdchk(input string nm, input logic [16:0] a, input logic [63:0] exp);
      drive(1'b0, 1'b1, a, 64'd0, 1'b0, 1'b0);
      n_vec++;
      if (rd_v !== 1'b1 || rd_data !== exp) begin
         n_bad++;
         $display("FAIL %s: got valid=%0b data=%h expected valid=1 data=%h", nm, rd_v, rd_data, exp);
      end
   endtask

   localparam logic [31:0] S1 = 32'h1;
   localparam logic [31:0] SA = 32'hACE1;
   localparam logic [63:0] SCR = 64'hDEAD_BEEF_0123_4567;

   initial begin
      logic bad;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; fdone = 1'b0; ferr = 1'b0;

      // reset reads, scratch, seed with same-cycle read
      addv(0,1,17'h0,0,0,0, 1,64'h0,0,0,S1);
      addv(0,1,17'h1,0,0,0, 1,64'h1,0,0,S1);
      addv(0,1,17'h2,0,0,0, 1,64'h0,0,0,S1);
      addv(0,1,17'h3,0,0,0, 1,64'h0,0,0,S1);
      addv(0,1,17'h4,0,0,0, 1,64'h0,0,0,S1);
      addv(0,1,17'h5,0,0,0, 1,64'h0,0,0,S1);
      addv(0,0,17'h0,0,0,0, 0,64'h0,0,0,S1);
      addv(1,0,17'h5,SCR,0,0, 0,64'h0,0,0,S1);
      addv(0,1,17'h5,0,0,0, 1,SCR,0,0,S1);
      addv(1,1,17'h1,64'hACE1,0,0, 1,64'h1,0,0,S1);
      addv(0,1,17'h1,0,0,0, 1,64'hACE1,0,0,S1);
      // target-3 run with one error
      addv(1,0,17'h0,64'h0000_0003_0000_0001,0,0, 0,0,1,1,SA);
      addv(0,0,17'h0,0,0,0, 0,0,0,1,SA);
      addv(0,1,17'h0,0,1,0, 1,64'h0000_0003_0000_0000,0,1,SA);
      addv(0,0,17'h0,0,1,1, 0,0,0,1,SA);
      addv(0,1,17'h2,0,0,0, 1,64'hA,0,1,SA);
      addv(0,0,17'h0,0,1,0, 0,0,0,0,SA);
      addv(0,1,17'h2,0,0,0, 1,64'hB,0,0,SA);
      addv(0,1,17'h2,0,0,0, 1,64'hC,0,0,SA);
      addv(0,1,17'h3,0,0,0, 1,64'h3,0,0,SA);
      addv(0,1,17'h4,0,0,0, 1,64'h1,0,0,SA);
      addv(1,0,17'h2,64'hC,0,0, 0,0,0,0,SA);
      addv(0,1,17'h2,0,0,0, 1,64'h0,0,0,SA);
      // continuous run, seed write mid-run, abort coinciding with a frame
      addv(1,0,17'h0,64'h0000_0002_0000_0005,0,0, 0,0,1,1,SA);
      addv(0,0,17'h0,0,0,0, 0,0,0,1,SA);
      addv(1,0,17'h1,64'h1234,1,0, 0,0,0,1,SA);
      addv(0,0,17'h0,0,1,0, 0,0,0,1,SA);
      addv(0,0,17'h0,0,1,0, 0,0,0,1,SA);
      addv(0,0,17'h0,0,1,0, 0,0,0,1,SA);
      addv(1,0,17'h0,64'h0000_0002_0000_0006,1,0, 0,0,0,0,SA);
      addv(0,1,17'h3,0,0,0, 1,64'h5,0,0,SA);
      addv(0,1,17'h2,0,0,0, 1,64'h0,0,0,SA);
      addv(0,1,17'h4,0,0,0, 1,64'h0,0,0,SA);
      // START with zero target is ignored
      addv(1,0,17'h0,64'h1,0,0, 0,0,0,0,SA);
      addv(0,1,17'h2,0,0,0, 1,64'h0,0,0,SA);
      addv(0,1,17'h0,0,0,0, 1,64'h0,0,0,SA);
      // unmapped offsets and ignored upper address bits
      addv(0,1,17'h9,0,0,0, 1,64'h5555_AAAA_0000_0009,0,0,SA);
      addv(1,0,17'h9,64'hFFFF_FFFF_FFFF_FFFF,0,0, 0,0,0,0,SA);
      addv(0,1,17'h1_0005,0,0,0, 1,SCR,0,0,SA);
      addv(0,1,17'h1,0,0,0, 1,64'h1234,0,0,SA);
      addv(0,1,17'h1FFFF,0,0,0, 1,64'h5555_AAAA_0001_FFFF,0,0,SA);

      repeat (3) @(posedge clk);
      #1;
      chk64("reset_outputs", {rd_v, bstart, bbusy, 29'd0, bseed}, {3'b000, 29'd0, S1});
      #2 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].wr, vt[i].rd, vt[i].a, vt[i].wd, vt[i].fd, vt[i].er);
         n_vec++;
         bad = (rd_v !== vt[i].ev) || (vt[i].ev && rd_data !== vt[i].erd) ||
               (bstart !== vt[i].es) || (bbusy !== vt[i].eb) || (bseed !== vt[i].esd) ||
               (sat_rd_v !== vt[i].ev) || (vt[i].ev && sat_rd_data !== vt[i].erd) ||
               (sat_start !== vt[i].es) || (sat_busy !== vt[i].eb) || (sat_seed !== vt[i].esd);
         if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%0b rd=%h start=%0b busy=%0b seed=%h (narrow v=%0b rd=%h) expected v=%0b rd=%h start=%0b busy=%0b seed=%h",
                     i, rd_v, rd_data, bstart, bbusy, bseed, sat_rd_v, sat_rd_data,
                     vt[i].ev, vt[i].erd, vt[i].es, vt[i].eb, vt[i].esd);
         end
      end

      // error counter saturation and W1C racing a set
      drive(1, 0, 17'h0, 64'h0000_0064_0000_0001, 0, 0);
      chk64("sat_run_start", {62'd0, bstart, bbusy}, 64'h3);
      chk64("seed_latched", {32'd0, bseed}, 64'h1234);
      drive(0, 0, 17'h0, 64'd0, 0, 0);
      for (int k = 0; k < 17; k++) drive(0, 0, 17'h0, 64'd0, 0, 1);
      rdchk("err_cnt_main", 17'h4, 64'd17);
      chk64("err_cnt_saturated", sat_rd_data, 64'hF);
      drive(1, 0, 17'h2, 64'h8, 0, 1);
      rdchk("err_w1c_vs_set", 17'h2, 64'hA);
      rdchk("err_cnt_sat_hold", 17'h4, 64'd18);
      chk64("err_cnt_saturated_hold", sat_rd_data, 64'hF);
      drive(1, 0, 17'h2, 64'h8, 0, 0);
      rdchk("err_w1c", 17'h2, 64'h2);
      drive(1, 0, 17'h0, 64'h0000_0064_0000_0002, 0, 0);
      chk64("abort_idle", {63'd0, bbusy}, 64'h0);

      // reset in the middle of a run
      drive(1, 0, 17'h0, 64'h0000_000A_0000_0001, 0, 0);
      drive(0, 0, 17'h0, 64'd0, 0, 0);
      drive(0, 0, 17'h0, 64'd0, 1, 0);
      drive(0, 0, 17'h0, 64'd0, 1, 0);
      rdchk("frame_cnt_pre_rst", 17'h3, 64'd2);
      rdchk("scratch_pre_rst", 17'h5, SCR);
      #2 rst = 1'b1;
      #1;
      chk64("rst_rd_data", rd_data, 64'd0);
      chk64("rst_ctl_outs", {rd_v, bstart, bbusy, 29'd0, bseed}, {3'b000, 29'd0, S1});
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk64("no_pulse_after_rst", {62'd0, bstart, bbusy}, 64'h0);
      rdchk("rst_frame_cnt", 17'h3, 64'd0);
      rdchk("rst_err_cnt", 17'h4, 64'd0);
      rdchk("rst_status", 17'h2, 64'd0);
      rdchk("rst_ctrl", 17'h0, 64'd0);
      rdchk("rst_seed", 17'h1, 64'h1);
      rdchk("rst_scratch", 17'h5, 64'd0);

      // FRAME_CNT read followed by an error, then ERR_CNT read
      drive(1, 0, 17'h0, 64'h0000_0032_0000_0001, 0, 0);
      drive(0, 0, 17'h0, 64'd0, 0, 0);
      drive(0, 0, 17'h0, 64'd0, 1, 1);
      drive(0, 0, 17'h0, 64'd0, 0, 1);
      rdchk("snap_frame_cnt", 17'h3, 64'd1);
      drive(0, 0, 17'h0, 64'd0, 0, 1);
`ifdef BIST_CH_CSR_SNAPSHOT_EN
      rdchk("snap_err_cnt", 17'h4, 64'd2);
`else
      rdchk("live_err_cnt", 17'h4, 64'd3);
`endif
      drive(1, 0, 17'h0, 64'h0000_0032_0000_0002, 0, 0);
      rdchk("final_status", 17'h2, 64'h8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
